buzzer_melody_player: RTL
=========================

Name: buzzer_melody_player

Overview:
Parametrised successor to the single-octave key buzzer. It synthesises a square wave for seven notes (Do–Si) over three octaves, with lowest-index priority when several keys are held, and adds a ROM-driven melody player with play/stop and loop control. It sits between the board key/switch inputs and the active-low piezo buzzer pin, and also drives the key LEDs.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz; all note and timing constants derive from it
DIV_W, 18, width of the tone half-period counter; must hold 2*(CLK_HZ/524)
NOTE_MS, 250, melody step duration in ms
DEB_MS, 10, debounce time in ms for the play key
MEL_LEN, 16, number of melody entries
MELODY, 48'h0539771F58D1, 3*MEL_LEN bits; entry i at [3i+2:3i]; code 0 = rest, 1..7 = Do..Si. Default sequence: 1,2,3,4,5,6,7,0,7,6,5,4,3,2,1,0

Ports:
CLK  input  1  system clock
RSTn  input  1  reset; one clock; reset is asynchronous and active-low
Key_In  input  8  active-low keys; [6:0] notes Do..Si, [7] play/stop
Oct_Sel  input  2  0 = low octave, 1 = middle, 2 = high, 3 = middle
Loop_En  input  1  1 = melody restarts at entry 0 after the last entry
Buzzer_Out  output  1  tone output; idle level 1
LED_Out  output  8  [6:0] one-hot active-high sounding note; [7] playing flag

Behaviour:
- Reset values: Buzzer_Out=1, LED_Out=0, playing=0, melody index=0, all counters=0, key sync flops=1 (released).
- Key_In is synchronised through 2 flops. Only synchronised values are used.
- Note select: the lowest-index synchronised low bit of [6:0] gives the manual note, code = index+1. If no key is low, the melody code is used when playing=1, else 0.
- Manual keys override the melody tone. The melody timer keeps advancing underneath.
- Base half-period HP(n) = CLK_HZ/(2*f), truncating integer division, with f = 262, 294, 330, 349, 392, 440, 494 Hz for Do..Si.
- Octave scaling: low = HP<<1, middle = HP, high = HP>>1.
- Tone counter counts 0..HPsel-1. On reaching HPsel-1 it clears and toggles Buzzer_Out, giving a period of exactly 2*HPsel cycles.
- On any change of the selected code or Oct_Sel, the counter clears on the next cycle; Buzzer_Out is not forced.
- Code 0 (silence): the counter is held at 0 and Buzzer_Out is forced to 1 on the next cycle.
- Latency from a Key_In edge to the new selection: 3 cycles (2 sync + 1 register).
- LED_Out[6:0] is registered: bit (code-1) is set when code≠0, all zero otherwise. LED_Out[7] = playing.
- Play key debounce: the synchronised bit [7] must hold a new level for DEB_MS*CLK_HZ/1000 consecutive cycles before it is accepted; any bounce restarts the count. An accepted falling edge toggles playing.
- Melody start (playing 0→1): index=0, step timer=0.
- Each step lasts NOTE_MS*CLK_HZ/1000 cycles, then index increments.
- End of the last step with Loop_En=1: index wraps to 0 and play continues.
- End of the last step with Loop_En=0: playing=0 and index=0.
- Stop (playing 1→0 via the key): index=0 and step timer=0 immediately. The tone goes silent unless a manual key is held.
- A play-key accept on the same cycle as end-of-melody: the toggle wins. The result is playing=0, with the end logic ignored.
- Asynchronous reset mid-tone or mid-melody returns all state to reset values immediately.

Test Plan:
(All scenarios use CLK_HZ=1_000_000, NOTE_MS=2, DEB_MS=1.)
1. Reset, then Key_In=8'hFE with Oct_Sel=1 -> LED_Out=8'h01 after 3 cycles. Buzzer_Out toggles every 1908 cycles (period 3816). Release key -> Buzzer_Out=1 within 4 cycles, LED_Out=0.
2. Key_In=8'hFE with Oct_Sel=0 -> half-period 3816. Switch to Oct_Sel=2 -> half-period 954 after a counter restart. Oct_Sel=3 -> 1908.
3. Key_In=8'b1101_1011 (Mi and La both low) -> Mi selected, LED_Out=8'h04, half-period 1515. Release Mi -> La, half-period 1136.
4. Pulse Key_In[7] low for 1500 cycles with 3 bounces in the first 200 -> exactly one toggle. LED_Out[7]=1, steps every 2000 cycles with Do then Re codes. Entry 7 is silent with Buzzer_Out=1. With Loop_En=0, playing=0 after 32000 cycles.
5. Loop_En=1 during play -> index wraps to entry 0 (LED_Out=8'h81). Hold Key_In[6] low mid-melody -> Si half-period 1012 and LED_Out[6:0]=7'h40; on release the melody resumes at the timer-advanced entry.
6. Assert RSTn low mid-melody while the tone is toggling -> Buzzer_Out=1 and LED_Out=0 asynchronously. After release, the block stays silent until a key press.

Source files
------------

// File: rtl/buzzer_melody_player.sv
// Seven-note, three-octave square-wave buzzer with lowest-index key priority
// and a ROM-driven melody player (play/stop key, optional looping).
`timescale 1ns/1ps
module buzzer_melody_player #(
    parameter int                   CLK_HZ  = 50_000_000,
    parameter int                   DIV_W   = 18,
    parameter int                   NOTE_MS = 250,
    parameter int                   DEB_MS  = 10,
    parameter int                   MEL_LEN = 16,
    parameter logic [3*MEL_LEN-1:0] MELODY  = 48'h0539771F58D1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [7:0] Key_In,
    input  logic [1:0] Oct_Sel,
    input  logic       Loop_En,
    output logic       Buzzer_Out,
    output logic [7:0] LED_Out
);
    localparam longint STEP_CYC = longint'(NOTE_MS) * longint'(CLK_HZ) / 1000;
    localparam longint DEB_CYC  = longint'(DEB_MS) * longint'(CLK_HZ) / 1000;
    localparam int     STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int     DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int     IDX_W    = (MEL_LEN > 1) ? $clog2(MEL_LEN) : 1;

    typedef enum logic {ST_IDLE, ST_PLAY} state_t;

    logic [7:0]        r_key_s1, r_key_s2;
    logic              r_play_stable;
    logic [DEB_W-1:0]  r_deb_cnt;
    state_t            r_state, w_state_next;
    logic [IDX_W-1:0]  r_idx, w_idx_next;
    logic [STEP_W-1:0] r_step_cnt, w_step_next;
    logic [2:0]        r_code;
    logic [1:0]        r_oct;
    logic [DIV_W-1:0]  r_tone_cnt;
    logic              r_buzz;
    logic [6:0]        r_led;

    logic [2:0]        w_man_code, w_mel_code, w_sel_code;
    logic [2:0]        w_mel_tab [MEL_LEN];
    logic [6:0]        w_led_next;
    logic [DIV_W-1:0]  w_hp_base, w_hp;
    logic              w_deb_accept, w_play_toggle, w_step_end, w_last, w_sel_change;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_key_s1 <= 8'hFF;
            r_key_s2 <= 8'hFF;
        end else begin
            r_key_s1 <= Key_In;
            r_key_s2 <= r_key_s1;
        end
    end

    // Play key must hold a new level for DEB_CYC consecutive cycles; bounces restart the count.
    assign w_deb_accept  = (r_key_s2[7] != r_play_stable) && (r_deb_cnt == DEB_W'(DEB_CYC - 1));
    assign w_play_toggle = w_deb_accept && !r_key_s2[7];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_play_stable <= 1'b1;
            r_deb_cnt     <= '0;
        end else if (r_key_s2[7] == r_play_stable) begin
            r_deb_cnt     <= '0;
        end else if (w_deb_accept) begin
            r_play_stable <= r_key_s2[7];
            r_deb_cnt     <= '0;
        end else begin
            r_deb_cnt     <= r_deb_cnt + DEB_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < MEL_LEN; gi++) begin : g_mel
            assign w_mel_tab[gi] = MELODY[3*gi +: 3];
        end
    endgenerate

    assign w_mel_code = w_mel_tab[r_idx];
    assign w_step_end = (r_step_cnt == STEP_W'(STEP_CYC - 1));
    assign w_last     = (r_idx == IDX_W'(MEL_LEN - 1));

    // A key toggle outranks the end-of-melody handling on the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_step_next  = r_step_cnt;
        if (w_play_toggle) begin
            w_state_next = (r_state == ST_IDLE) ? ST_PLAY : ST_IDLE;
            w_idx_next   = '0;
            w_step_next  = '0;
        end else if (r_state == ST_PLAY) begin
            if (w_step_end) begin
                w_step_next = '0;
                if (w_last) begin
                    w_idx_next = '0;
                    if (!Loop_En) w_state_next = ST_IDLE;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end else begin
                w_step_next = r_step_cnt + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_step_cnt <= w_step_next;
        end
    end

    // Lowest-index held key wins: scan downwards so the last match is the smallest index.
    always_comb begin
        w_man_code = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!r_key_s2[i]) w_man_code = 3'(i + 1);
        end
    end

    assign w_sel_code = (w_man_code != 3'd0) ? w_man_code :
                        ((r_state == ST_PLAY) ? w_mel_code : 3'd0);

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_led
            assign w_led_next[gi] = (w_sel_code == 3'(gi + 1));
        end
    endgenerate

    always_comb begin
        w_hp_base = '0;
        case (r_code)
            3'd1:    w_hp_base = DIV_W'(CLK_HZ / (2 * 262));
            3'd2:    w_hp_base = DIV_W'(CLK_HZ / (2 * 294));
            3'd3:    w_hp_base = DIV_W'(CLK_HZ / (2 * 330));
            3'd4:    w_hp_base = DIV_W'(CLK_HZ / (2 * 349));
            3'd5:    w_hp_base = DIV_W'(CLK_HZ / (2 * 392));
            3'd6:    w_hp_base = DIV_W'(CLK_HZ / (2 * 440));
            3'd7:    w_hp_base = DIV_W'(CLK_HZ / (2 * 494));
            default: w_hp_base = '0;
        endcase
        case (r_oct)
            2'd0:    w_hp = w_hp_base << 1;
            2'd2:    w_hp = w_hp_base >> 1;
            default: w_hp = w_hp_base;
        endcase
    end

    assign w_sel_change = (w_sel_code != r_code) || (Oct_Sel != r_oct);

    // A note or octave change restarts the half-period without disturbing the output level.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_code     <= 3'd0;
            r_oct      <= 2'd0;
            r_led      <= '0;
            r_tone_cnt <= '0;
            r_buzz     <= 1'b1;
        end else begin
            r_code <= w_sel_code;
            r_oct  <= Oct_Sel;
            r_led  <= w_led_next;
            if (w_sel_change) begin
                r_tone_cnt <= '0;
            end else if (r_code == 3'd0) begin
                r_tone_cnt <= '0;
                r_buzz     <= 1'b1;
            end else if (r_tone_cnt == w_hp - DIV_W'(1)) begin
                r_tone_cnt <= '0;
                r_buzz     <= ~r_buzz;
            end else begin
                r_tone_cnt <= r_tone_cnt + DIV_W'(1);
            end
        end
    end

    assign Buzzer_Out = r_buzz;
    assign LED_Out    = {(r_state == ST_PLAY), r_led};

endmodule
